// File: rtl/bmm150_pkg.sv
// bmm150_pkg: register map, chip constants, error codes and state types for the BMM150 sequencer
package bmm150_pkg;
    localparam logic [6:0] CHIP_ID    = 7'h40;
    localparam logic [6:0] DATA_X_LSB = 7'h42;
    localparam logic [6:0] DATA_X_MSB = 7'h43;
    localparam logic [6:0] DATA_Y_LSB = 7'h44;
    localparam logic [6:0] DATA_Y_MSB = 7'h45;
    localparam logic [6:0] DATA_Z_LSB = 7'h46;
    localparam logic [6:0] DATA_Z_MSB = 7'h47;
    localparam logic [6:0] RHALL_LSB  = 7'h48;
    localparam logic [6:0] RHALL_MSB  = 7'h49;
    localparam logic [6:0] PWR_CTRL   = 7'h4B;
    localparam logic [6:0] OPMODE     = 7'h4C;
    localparam logic [7:0] CHIP_ID_VAL   = 8'h32;
    localparam logic [7:0] PWR_ON_VAL    = 8'h01;
    localparam logic [7:0] OPMODE_NORMAL = 8'h00;
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CHIP_ID = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    typedef enum logic [3:0] {
        IDLE, PWR_ON, STARTUP_WAIT, READ_ID, CHECK_ID,
        SET_OPMODE, PERIOD_WAIT, READ_DATA, PUBLISH, ERROR
    } ctrl_state_t;
    typedef enum logic {PH_ISSUE, PH_WAIT} txn_phase_t;
endpackage

// File: rtl/bmm150_interval_timer.sv
// bmm150_interval_timer: loadable down-counter that saturates at zero; o_tc marks the last counted cycle
module bmm150_interval_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_tc,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else if (i_load) r_cnt <= i_val;
        else if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
    end
    assign o_tc   = r_cnt == W'(1);
    assign o_zero = r_cnt == '0;
endmodule

// File: rtl/bmm150_ctrl.sv
// bmm150_ctrl: BMM150 init/poll sequencer over a single-byte SPI master, publishing X/Y/Z/RHALL samples
module bmm150_ctrl
    import bmm150_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int STARTUP_US  = 3000,
    parameter int SAMPLE_HZ   = 10,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        spi_enable,
    output logic        spi_start,
    output logic        spi_rw,
    output logic [6:0]  spi_reg_addr,
    output logic [7:0]  spi_tx_data,
    input  logic [7:0]  spi_rx_data,
    input  logic        spi_busy,
    input  logic        spi_done,
    output logic        init_done,
    output logic        data_valid,
    output logic [12:0] mag_x,
    output logic [12:0] mag_y,
    output logic [14:0] mag_z,
    output logic [13:0] rhall,
    output logic        error,
    output logic [1:0]  error_code
);
    localparam int STARTUP_CYC = STARTUP_US * (CLK_HZ / 1_000_000);
    localparam int SAMPLE_CYC  = CLK_HZ / SAMPLE_HZ;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0] MAX_R   = RW'(MAX_RETRY);
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYC - 1);

    ctrl_state_t r_state;
    txn_phase_t  r_ph;
    logic        r_spi_enable, r_spi_start, r_rw, r_skip;
    logic [6:0]  r_addr;
    logic [7:0]  r_tx, r_rx;
    logic [2:0]  r_idx;
    logic [RW-1:0] r_retry;
    logic [7:0]  r_b [8];
    logic        r_init_done, r_data_valid, r_error;
    logic [1:0]  r_code;
    logic [12:0] r_x, r_y;
    logic [14:0] r_z;
    logic [13:0] r_rh;
    logic        r_wait_ld, r_to_ld;
    logic [31:0] r_wait_val;

    logic        w_wait_tc, w_wait_zero, w_to_tc, w_to_zero;
    logic        w_is_acc, w_rw, w_done, w_to, w_wait_exp;
    logic [6:0]  w_addr;
    logic [7:0]  w_tx;

    bmm150_interval_timer #(.W(32)) u_wait (
        .clk(clk), .rst(rst), .i_load(r_wait_ld), .i_val(r_wait_val),
        .o_tc(w_wait_tc), .o_zero(w_wait_zero)
    );

    bmm150_interval_timer #(.W(TW)) u_timeout (
        .clk(clk), .rst(rst), .i_load(r_to_ld), .i_val(TO_LOAD),
        .o_tc(w_to_tc), .o_zero(w_to_zero)
    );

    always_comb begin
        w_is_acc = r_state inside {PWR_ON, READ_ID, SET_OPMODE, READ_DATA};
        w_rw     = r_state inside {READ_ID, READ_DATA};
        w_addr   = r_state == PWR_ON ? PWR_CTRL : r_state == READ_ID ? CHIP_ID :
                   r_state == SET_OPMODE ? OPMODE : DATA_X_LSB + 7'(r_idx);
        w_tx     = r_state == PWR_ON ? PWR_ON_VAL : OPMODE_NORMAL;
        // done in the start cycle or the one right after it belongs to no transfer of ours
        w_done   = w_is_acc && r_ph == PH_WAIT && spi_done && !r_spi_start && !r_skip;
        w_to     = w_is_acc && r_ph == PH_WAIT && !r_to_ld && (w_to_tc || w_to_zero);
        w_wait_exp = !r_wait_ld && (w_wait_tc || w_wait_zero);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ph <= PH_ISSUE;
            r_spi_enable <= 1'b0;
            r_spi_start <= 1'b0;
            r_rw <= 1'b0;
            r_skip <= 1'b0;
            r_addr <= '0;
            r_tx <= '0;
            r_rx <= '0;
            r_idx <= '0;
            r_retry <= '0;
            for (int i = 0; i < 8; i++) r_b[i] <= '0;
            r_init_done <= 1'b0;
            r_data_valid <= 1'b0;
            r_error <= 1'b0;
            r_code <= ERR_NONE;
            r_x <= '0;
            r_y <= '0;
            r_z <= '0;
            r_rh <= '0;
            r_wait_ld <= 1'b0;
            r_to_ld <= 1'b0;
            r_wait_val <= '0;
        end else begin
            r_spi_enable <= enable;
            r_spi_start <= 1'b0;
            r_skip <= r_spi_start;
            r_wait_ld <= 1'b0;
            r_to_ld <= 1'b0;
            r_data_valid <= 1'b0;
            if (!enable) begin
                r_state <= IDLE;
                r_ph <= PH_ISSUE;
                r_init_done <= 1'b0;
                r_retry <= '0;
                r_error <= 1'b0;
                r_code <= ERR_NONE;
            end else if (w_is_acc && r_ph == PH_ISSUE) begin
                if (!spi_busy) begin
                    r_spi_start <= 1'b1;
                    r_rw <= w_rw;
                    r_addr <= w_addr;
                    r_tx <= w_tx;
                    r_ph <= PH_WAIT;
                    r_to_ld <= 1'b1;
                end
            end else if (w_done) begin
                r_ph <= PH_ISSUE;
                r_rx <= spi_rx_data;
                case (r_state)
                    PWR_ON: begin
                        r_state <= STARTUP_WAIT;
                        r_wait_ld <= 1'b1;
                        r_wait_val <= 32'(STARTUP_CYC);
                    end
                    READ_ID: r_state <= CHECK_ID;
                    SET_OPMODE: begin
                        r_state <= READ_DATA;
                        r_init_done <= 1'b1;
                        r_idx <= '0;
                        r_wait_ld <= 1'b1;
                        r_wait_val <= 32'(SAMPLE_CYC - 1);
                    end
                    default: begin
                        r_b[r_idx] <= spi_rx_data;
                        r_idx <= r_idx + 3'd1;
                        if (r_addr == RHALL_MSB) r_state <= PUBLISH;
                    end
                endcase
            end else if (w_to) begin
                r_state <= ERROR;
                r_ph <= PH_ISSUE;
                r_init_done <= 1'b0;
                r_error <= 1'b1;
                r_code <= ERR_TIMEOUT;
            end else begin
                case (r_state)
                    IDLE: r_state <= PWR_ON;
                    STARTUP_WAIT: if (w_wait_exp) r_state <= READ_ID;
                    CHECK_ID: begin
                        if (r_rx == CHIP_ID_VAL) begin
                            r_state <= SET_OPMODE;
                        end else if (r_retry < MAX_R) begin
                            r_retry <= r_retry + RW'(1);
                            r_state <= STARTUP_WAIT;
                            r_wait_ld <= 1'b1;
                            r_wait_val <= 32'(STARTUP_CYC);
                        end else begin
                            r_state <= ERROR;
                            r_error <= 1'b1;
                            r_code <= ERR_CHIP_ID;
                        end
                    end
                    PUBLISH: begin
                        if (r_b[6][0]) begin
                            r_x <= {r_b[1], r_b[0][7:3]};
                            r_y <= {r_b[3], r_b[2][7:3]};
                            r_z <= {r_b[5], r_b[4][7:1]};
                            r_rh <= {r_b[7], r_b[6][7:2]};
                            r_data_valid <= 1'b1;
                        end
                        r_state <= PERIOD_WAIT;
                    end
                    PERIOD_WAIT: begin
                        if (w_wait_exp) begin
                            r_state <= READ_DATA;
                            r_idx <= '0;
                            r_wait_ld <= 1'b1;
                            r_wait_val <= 32'(SAMPLE_CYC - 1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign spi_enable   = r_spi_enable;
    assign spi_start    = r_spi_start;
    assign spi_rw       = r_rw;
    assign spi_reg_addr = r_addr;
    assign spi_tx_data  = r_tx;
    assign init_done    = r_init_done;
    assign data_valid   = r_data_valid;
    assign mag_x        = r_x;
    assign mag_y        = r_y;
    assign mag_z        = r_z;
    assign rhall        = r_rh;
    assign error        = r_error;
    assign error_code   = r_code;
endmodule

// File: tb/tb_bmm150_ctrl.sv
// tb_bmm150_ctrl: scoreboard bench with a behavioural SPI slave for bmm150_ctrl
module tb_bmm150_ctrl;
    logic        clk = 1'b0;
    logic        rst, enable;
    logic        spi_enable, spi_start, spi_rw;
    logic [6:0]  spi_reg_addr;
    logic [7:0]  spi_tx_data, spi_rx_data;
    logic        spi_busy, spi_done;
    logic        init_done, data_valid, error;
    logic [12:0] mag_x, mag_y;
    logic [14:0] mag_z;
    logic [13:0] rhall;
    logic [1:0]  error_code;

    bmm150_ctrl #(
        .CLK_HZ(1_000_000), .STARTUP_US(10), .SAMPLE_HZ(1000), .MAX_RETRY(3), .TIMEOUT_CYC(64)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .spi_enable(spi_enable), .spi_start(spi_start), .spi_rw(spi_rw),
        .spi_reg_addr(spi_reg_addr), .spi_tx_data(spi_tx_data), .spi_rx_data(spi_rx_data),
        .spi_busy(spi_busy), .spi_done(spi_done), .init_done(init_done),
        .data_valid(data_valid), .mag_x(mag_x), .mag_y(mag_y), .mag_z(mag_z),
        .rhall(rhall), .error(error), .error_code(error_code)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0, n_dv = 0, cyc = 0;
    int t_pwr = 0, t_id = 0, t_start = 0, t42_prev = 0, t42_last = 0;
    logic [15:0] exp_q[$];
    logic [54:0] sample_q[$];
    logic [7:0]  mem [128];
    logic        m_busy = 1'b0, m_hang = 1'b0;
    logic [6:0]  m_addr = '0;
    int          m_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_txn(input logic rw, input logic [6:0] a, input logic [7:0] d);
        exp_q.push_back({rw, a, d});
    endtask

    task automatic push_init();
        push_txn(1'b0, 7'h4B, 8'h01);
        push_txn(1'b1, 7'h40, 8'h00);
        push_txn(1'b0, 7'h4C, 8'h00);
    endtask

    task automatic push_burst();
        for (int i = 0; i < 8; i++) push_txn(1'b1, 7'(7'h42 + i), 8'h00);
    endtask

    task automatic set_bytes(input logic [63:0] b);
        for (int i = 0; i < 8; i++) mem[7'h42 + i] = b[8*i +: 8];
    endtask

    // SPI slave: 4 cycles busy after a start, then a one-cycle done with read data
    initial begin
        logic [15:0] e;
        logic [54:0] s;
        forever begin
            @(negedge clk);
            spi_done = 1'b0;
            if (!spi_enable) begin
                m_busy = 1'b0;
                m_cnt = 0;
            end else if (spi_start) begin
                if (exp_q.size() == 0) chk("unexp_start", 32'(spi_start), 0);
                else begin
                    e = exp_q.pop_front();
                    chk("txn", 32'({spi_rw, spi_reg_addr, spi_tx_data}), 32'(e));
                end
                if (spi_reg_addr == 7'h4B) t_pwr = cyc;
                if (spi_reg_addr == 7'h40) t_id = cyc;
                if (spi_reg_addr == 7'h42) begin
                    t42_prev = t42_last;
                    t42_last = cyc;
                end
                t_start = cyc;
                m_addr = spi_reg_addr;
                m_busy = 1'b1;
                m_cnt = 3;
            end else if (m_busy && m_cnt != 0) begin
                m_cnt--;
            end else if (m_busy && !(m_hang && m_addr >= 7'h42)) begin
                m_busy = 1'b0;
                spi_done = 1'b1;
                spi_rx_data = mem[m_addr];
            end
            spi_busy = m_busy;
            if (data_valid) begin
                n_dv++;
                if (sample_q.size() == 0) chk("unexp_dv", 32'(data_valid), 0);
                else begin
                    s = sample_q.pop_front();
                    chk("mag_x", 32'(mag_x), 32'(s[54:42]));
                    chk("mag_y", 32'(mag_y), 32'(s[41:29]));
                    chk("mag_z", 32'(mag_z), 32'(s[28:14]));
                    chk("rhall", 32'(rhall), 32'(s[13:0]));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        spi_done = 1'b0;
        spi_busy = 1'b0;
        spi_rx_data = '0;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(spi_start), 0);
        chk("rst_init", 32'(init_done), 0);
        chk("rst_err", 32'(error), 0);
        chk("rst_spi_en", 32'(spi_enable), 0);
        chk("rst_dv", 32'(data_valid), 0);
        chk("rst_magx", 32'(mag_x), 0);
        rst = 1'b0;

        mem[7'h40] = 8'h32;
        set_bytes(64'h80057FFE0008FFF8);
        push_init();
        push_burst();
        sample_q.push_back({13'h1FFF, 13'h0001, 15'h3FFF, 14'h2001});
        enable = 1'b1;
        for (int i = 0; i < 200 && !init_done; i++) @(negedge clk);
        chk("init_done", 32'(init_done), 1);
        chk("init_err", 32'(error), 0);
        chk("spi_en", 32'(spi_enable), 1);
        chk("startup_gap", 32'(t_id - t_pwr >= 15), 1);
        for (int i = 0; i < 200 && sample_q.size() != 0; i++) @(negedge clk);
        chk("dv_cnt1", 32'(n_dv), 1);
        chk("burst1_left", 32'(exp_q.size()), 0);

        mem[7'h48] = 8'h04;
        push_burst();
        for (int i = 0; i < 1100 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (12) @(negedge clk);
        chk("nr_dv_cnt", 32'(n_dv), 1);
        chk("nr_hold_x", 32'(mag_x), 32'h1FFF);
        chk("nr_hold_y", 32'(mag_y), 32'h0001);
        chk("nr_hold_rh", 32'(rhall), 32'h2001);
        chk("period", 32'(t42_last - t42_prev), 1000);

        set_bytes(64'hFFFD80007FF88000);
        push_burst();
        for (int i = 0; i < 1100 && exp_q.size() > 5; i++) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("ab_init", 32'(init_done), 0);
        chk("ab_start", 32'(spi_start), 0);
        chk("ab_spi_en", 32'(spi_enable), 0);
        exp_q.delete();
        repeat (20) @(negedge clk);
        chk("ab_hold_x", 32'(mag_x), 32'h1FFF);
        chk("ab_hold_z", 32'(mag_z), 32'h3FFF);
        chk("ab_dv_cnt", 32'(n_dv), 1);
        push_init();
        push_burst();
        sample_q.push_back({13'h1000, 13'h0FFF, 15'h4000, 14'h3FFF});
        enable = 1'b1;
        for (int i = 0; i < 200 && !init_done; i++) @(negedge clk);
        chk("re_init", 32'(init_done), 1);
        for (int i = 0; i < 200 && sample_q.size() != 0; i++) @(negedge clk);
        chk("re_dv_cnt", 32'(n_dv), 2);

        enable = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        mem[7'h40] = 8'h00;
        push_txn(1'b0, 7'h4B, 8'h01);
        for (int i = 0; i < 4; i++) push_txn(1'b1, 7'h40, 8'h00);
        enable = 1'b1;
        for (int i = 0; i < 300 && !error; i++) @(negedge clk);
        chk("id_err", 32'(error), 1);
        chk("id_code", 32'(error_code), 1);
        chk("id_init", 32'(init_done), 0);
        repeat (50) @(negedge clk);
        chk("id_reads", 32'(exp_q.size()), 0);
        chk("id_sticky", 32'(error), 1);
        enable = 1'b0;
        @(negedge clk);
        chk("id_clr_err", 32'(error), 0);
        chk("id_clr_code", 32'(error_code), 0);
        mem[7'h40] = 8'h32;
        push_init();
        push_burst();
        sample_q.push_back({13'h1000, 13'h0FFF, 15'h4000, 14'h3FFF});
        enable = 1'b1;
        for (int i = 0; i < 200 && !init_done; i++) @(negedge clk);
        chk("id_rerun", 32'(init_done), 1);
        for (int i = 0; i < 200 && sample_q.size() != 0; i++) @(negedge clk);
        chk("id_dv_cnt", 32'(n_dv), 3);

        m_hang = 1'b1;
        push_txn(1'b1, 7'h42, 8'h00);
        for (int i = 0; i < 1100 && exp_q.size() != 0; i++) @(negedge clk);
        for (int i = 0; i < 100 && !error; i++) @(negedge clk);
        chk("to_cycles", 32'(cyc - t_start), 64);
        chk("to_err", 32'(error), 1);
        chk("to_code", 32'(error_code), 2);
        chk("to_init", 32'(init_done), 0);
        repeat (20) @(negedge clk);
        chk("to_dv_cnt", 32'(n_dv), 3);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
